// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver. It oversamples the line with a per-bit
//             counter and outputs good bytes with a one-cycle valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_Serial,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int            CW          = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_CLEAN     = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] clk_count_q, clk_count_d;
    logic [2:0]    bit_index_q, bit_index_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_busy_q, rx_busy_d;
    logic          rx_s;

    assign sync_d = {sync_q[0], Rx_Serial};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_count_d = '0;
                bit_index_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // A start bit that is no longer low at mid-bit is treated as a glitch
                if (clk_count_q == C_HALF_LAST) begin
                    clk_count_d = '0;
                    state_d     = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_count_q == C_BIT_LAST) begin
                    clk_count_d = '0;
                    shift_d     = {rx_s, shift_q[7:1]};
                    if (bit_index_q == 3'd7) begin
                        bit_index_d = '0;
                        state_d     = S_STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_count_q == C_BIT_LAST) begin
                    clk_count_d = '0;
                    if (rx_s) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_CLEAN;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end
            S_CLEAN: begin
                state_d = S_IDLE;
            end
            S_WAIT_IDLE: begin
                // Hold here through a break so it reports only one framing error
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule
`default_nettype wire
